// File: rtl/fifo_read_streamer.sv
// -----------------------------------------------------------------------------
// fifo_read_streamer
//
// Reader-side companion to the circular-queue FIFO controller and its
// dual-port RAM. It watches the FIFO empty flag and issues single-cycle read
// pulses. It tracks the RAM's fixed read latency with a small valid-bit pipe.
// It lands each returning word in a 4-entry elastic buffer, which presents the
// words on a valid/ready stream.
//
// Read requests are credit-limited: a read is only issued while buffered plus
// in-flight words leave room for it. Because of this, a stalled consumer can
// never overflow the buffer.
//
// Parameters:
//   WIDTH   data word width
//   RD_LAT  cycles from read pulse to the cycle rd_data holds the word (1 or 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   en          enable draining of the FIFO
//   empty       FIFO empty flag
//   rd_data     RAM read data, valid RD_LAT cycles after a read pulse
//   read        read request pulse to the FIFO controller
//   out_valid   out_data holds a word
//   out_data    head word of the elastic buffer
//   out_ready   downstream accepts the word this cycle
//   busy        block is not IDLE
//   word_count  downstream handshakes since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_read_streamer #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             read,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      word_count
);

  // Must be at least RD_LAT+2 for full throughput with out_ready held high.
  localparam int BUF_DEPTH = 4;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int INF_W     = $clog2(RD_LAT + 1);
  localparam int SUM_W     = OCC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [RD_LAT-1:0]      pipe_q, pipe_d;
  logic [WIDTH-1:0]       mem_q [BUF_DEPTH];
  logic [WIDTH-1:0]       mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [15:0]            word_count_q, word_count_d;

  logic [INF_W-1:0]       inflight;
  logic [SUM_W-1:0]       credit_used;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words already requested but not yet landed.
  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + INF_W'(pipe_q[i]);
    end
  end

  assign credit_used = SUM_W'(occ_q) + SUM_W'(inflight);
  assign read        = (state_q == RUN) && !empty &&
                       (credit_used < SUM_W'(BUF_DEPTH));

  // The last pipe stage marks the cycle in which rd_data carries the word.
  assign push      = pipe_q[RD_LAT-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[head_q];
  assign busy      = (state_q != IDLE);
  assign word_count = word_count_q;

  always_comb begin
    state_d      = state_q;
    pipe_d       = '0;
    mem_d        = mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    word_count_d = word_count_q;

    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if ((inflight == '0) && (occ_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pipe_d[0] = read;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (push) begin
      mem_d[tail_q] = rd_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d       = ptr_inc(head_q);
      word_count_d = word_count_q + 16'd1;
    end

    // A simultaneous push and pop leaves occupancy unchanged.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge value regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      pipe_q       <= '0;
      // NOTE: the buffer storage is reset too, so out_data reads 0 after reset
      // instead of a stale word.
      mem_q        <= '{default: '0};
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pipe_q       <= pipe_d;
      mem_q        <= mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      word_count_q <= word_count_d;
    end
  end

  // The credit rule makes this unreachable; firing means the credit logic broke.
  push_into_full_buffer: assert property (
    @(posedge clk) disable iff (!reset) !(push && (occ_q == OCC_W'(BUF_DEPTH)))
  );

endmodule

// File: tb/tb_fifo_read_streamer.sv
// -----------------------------------------------------------------------------
// Directed testbench for fifo_read_streamer.
//
// Instance A uses RD_LAT=1 and instance B uses RD_LAT=2. Each instance has its
// own RAM model. The model returns 1, 2, 3, ... in read order and restarts at
// 1 on reset.
//
// Cycle convention: inputs are driven 1 time unit after a rising edge, and
// outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_fifo_read_streamer;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       en_a, empty_a, ready_a, read_a, valid_a, busy_a;
  logic [7:0] rdata_a, data_a, cnt_a;
  logic [15:0] wc_a;

  logic       en_b, empty_b, ready_b, read_b, valid_b, busy_b;
  logic [7:0] rdata_b, data_b, cnt_b, stage_b;
  logic [15:0] wc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_read_streamer #(.WIDTH(8), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset_n), .en(en_a), .empty(empty_a), .rd_data(rdata_a),
    .read(read_a), .out_valid(valid_a), .out_data(data_a), .out_ready(ready_a),
    .busy(busy_a), .word_count(wc_a)
  );

  fifo_read_streamer #(.WIDTH(8), .RD_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset_n), .en(en_b), .empty(empty_b), .rd_data(rdata_b),
    .read(read_b), .out_valid(valid_b), .out_data(data_b), .out_ready(ready_b),
    .busy(busy_b), .word_count(wc_b)
  );

  // RAM model, latency 1: the word for a read in cycle t is on rdata in t+1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_a   <= 8'd1;
      rdata_a <= 8'd0;
    end else if (read_a) begin
      rdata_a <= cnt_a;
      cnt_a   <= cnt_a + 8'd1;
    end
  end

  // RAM model, latency 2: the word for a read in cycle t is on rdata in t+2.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_b   <= 8'd1;
      stage_b <= 8'd0;
      rdata_b <= 8'd0;
    end else begin
      if (read_b) begin
        stage_b <= cnt_b;
        cnt_b   <= cnt_b + 8'd1;
      end
      rdata_b <= stage_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    en_a = 1'b0; empty_a = 1'b1; ready_a = 1'b0;
    en_b = 1'b0; empty_b = 1'b1; ready_b = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en_a = 1'b0; empty_a = 1'b1; ready_a = 1'b0;
    en_b = 1'b0; empty_b = 1'b1; ready_b = 1'b0;
    #1;
    n_checks++; if (read_a !== 1'b0) begin n_fail++; $display("FAIL reset_read_a: got %b want 0", read_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_checks++; if (wc_a !== 16'd0) begin n_fail++; $display("FAIL reset_wc_a: got %0d want 0", wc_a); end
    n_checks++; if (data_a !== 8'd0) begin n_fail++; $display("FAIL reset_data_a: got %0d want 0", data_a); end
    n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    tick();
    reset_n = 1'b1;
  endtask

  // Continuous stream, RD_LAT=1. The first read is in c1, so the first word
  // appears in c3.
  task automatic test_stream();
    apply_reset();
    en_a = 1'b1; empty_a = 1'b0; ready_a = 1'b1;
    #1;
    n_checks++; if (read_a !== 1'b0) begin n_fail++; $display("FAIL stream_c0_read: got %b want 0", read_a); end
    tick(); #1;
    n_checks++; if (read_a !== 1'b1) begin n_fail++; $display("FAIL stream_c1_read: got %b want 1", read_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL stream_c1_busy: got %b want 1", busy_a); end
    tick(); #1;
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL stream_c2_valid: got %b want 0", valid_a); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, valid_a); end
      n_checks++; if (data_a !== 8'(k + 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0d want %0d", k, data_a, k + 1); end
      n_checks++; if (wc_a !== 16'(k)) begin n_fail++; $display("FAIL stream_wc[%0d]: got %0d want %0d", k, wc_a, k); end
    end
  endtask

  // Continues from test_stream at c5. out_ready is low from c6 to c11.
  task automatic test_backpressure();
    tick(); ready_a = 1'b0; #1;                        // c6
    n_checks++; if (read_a !== 1'b1) begin n_fail++; $display("FAIL bp_c6_read: got %b want 1", read_a); end
    tick(); #1;                                        // c7
    n_checks++; if (read_a !== 1'b1) begin n_fail++; $display("FAIL bp_c7_read: got %b want 1", read_a); end
    for (int k = 8; k <= 11; k++) begin
      tick(); #1;
      n_checks++; if (read_a !== 1'b0) begin n_fail++; $display("FAIL bp_c%0d_read: got %b want 0", k, read_a); end
      n_checks++; if ({valid_a, data_a} !== {1'b1, 8'd4}) begin n_fail++; $display("FAIL bp_c%0d_hold: got v=%b d=%0d want v=1 d=4", k, valid_a, data_a); end
    end
    tick(); ready_a = 1'b1; #1;                        // c12
    n_checks++; if (read_a !== 1'b0) begin n_fail++; $display("FAIL bp_c12_read: got %b want 0", read_a); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin tick(); #1; end
      if (k == 1) begin
        n_checks++; if (read_a !== 1'b1) begin n_fail++; $display("FAIL bp_resume_read: got %b want 1", read_a); end
      end
      n_checks++; if ({valid_a, data_a} !== {1'b1, 8'(4 + k)}) begin n_fail++; $display("FAIL bp_seq[%0d]: got v=%b d=%0d want v=1 d=%0d", k, valid_a, data_a, 4 + k); end
    end
    tick(); #1;                                        // c18
    n_checks++; if (wc_a !== 16'd9) begin n_fail++; $display("FAIL bp_wc: got %0d want 9", wc_a); end
  endtask

  // Reads occur in c1 to c3, and empty rises in c4.
  task automatic test_empty_midburst();
    apply_reset();
    en_a = 1'b1; empty_a = 1'b0; ready_a = 1'b1;
    #1;
    tick(); tick(); tick(); #1;                        // c3
    n_checks++; if (read_a !== 1'b1) begin n_fail++; $display("FAIL empty_c3_read: got %b want 1", read_a); end
    n_checks++; if (data_a !== 8'd1) begin n_fail++; $display("FAIL empty_c3_data: got %0d want 1", data_a); end
    tick(); empty_a = 1'b1; #1;                        // c4
    n_checks++; if (read_a !== 1'b0) begin n_fail++; $display("FAIL empty_c4_read: got %b want 0", read_a); end
    n_checks++; if ({valid_a, data_a} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL empty_c4_word: got v=%b d=%0d want v=1 d=2", valid_a, data_a); end
    tick(); #1;                                        // c5
    n_checks++; if ({valid_a, data_a} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL empty_c5_word: got v=%b d=%0d want v=1 d=3", valid_a, data_a); end
    for (int k = 6; k <= 8; k++) begin
      tick(); #1;
      n_checks++; if ({read_a, valid_a} !== 2'b00) begin n_fail++; $display("FAIL empty_c%0d_idle: got read=%b v=%b want 0 0", k, read_a, valid_a); end
    end
    n_checks++; if (wc_a !== 16'd3) begin n_fail++; $display("FAIL empty_wc: got %0d want 3", wc_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b want 1", busy_a); end
  endtask

  // RD_LAT=2, en drops in c5. At DRAIN entry (c6) word 3 is buffered and
  // words 4 and 5 are in flight. An en pulse in c7 must be ignored.
  task automatic test_drain();
    apply_reset();
    en_b = 1'b1; empty_b = 1'b0; ready_b = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) tick();
    en_b = 1'b0; #1;                                   // c5
    n_checks++; if (read_b !== 1'b1) begin n_fail++; $display("FAIL drain_c5_read: got %b want 1", read_b); end
    n_checks++; if (data_b !== 8'd2) begin n_fail++; $display("FAIL drain_c5_data: got %0d want 2", data_b); end
    tick(); #1;                                        // c6
    n_checks++; if ({read_b, busy_b, valid_b, data_b} !== {3'b011, 8'd3}) begin n_fail++; $display("FAIL drain_c6: got r=%b b=%b v=%b d=%0d want r=0 b=1 v=1 d=3", read_b, busy_b, valid_b, data_b); end
    tick(); en_b = 1'b1; #1;                           // c7
    n_checks++; if ({read_b, valid_b, data_b} !== {2'b01, 8'd4}) begin n_fail++; $display("FAIL drain_c7: got r=%b v=%b d=%0d want r=0 v=1 d=4", read_b, valid_b, data_b); end
    tick(); en_b = 1'b0; #1;                           // c8
    n_checks++; if ({read_b, valid_b, data_b} !== {2'b01, 8'd5}) begin n_fail++; $display("FAIL drain_c8: got r=%b v=%b d=%0d want r=0 v=1 d=5", read_b, valid_b, data_b); end
    tick(); #1;                                        // c9
    n_checks++; if ({read_b, valid_b, busy_b} !== 3'b001) begin n_fail++; $display("FAIL drain_c9: got r=%b v=%b b=%b want 0 0 1", read_b, valid_b, busy_b); end
    tick(); #1;                                        // c10
    n_checks++; if ({read_b, busy_b} !== 2'b00) begin n_fail++; $display("FAIL drain_c10: got r=%b b=%b want 0 0", read_b, busy_b); end
    n_checks++; if (wc_b !== 16'd5) begin n_fail++; $display("FAIL drain_wc: got %0d want 5", wc_b); end
  endtask

  // Reset asserted mid-burst, between clock edges.
  task automatic test_async_reset();
    apply_reset();
    en_a = 1'b1; empty_a = 1'b0; ready_a = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) tick();
    #1;                                                // c4
    n_checks++; if ({valid_a, wc_a} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL arst_pre: got v=%b wc=%0d want v=1 wc=1", valid_a, wc_a); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({read_a, valid_a, busy_a} !== 3'b000) begin n_fail++; $display("FAIL arst_flags: got r=%b v=%b b=%b want 0 0 0", read_a, valid_a, busy_a); end
    n_checks++; if ({wc_a, data_a} !== 24'd0) begin n_fail++; $display("FAIL arst_values: got wc=%0d d=%0d want 0 0", wc_a, data_a); end
    en_a = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if ({read_a, valid_a} !== 2'b00) begin n_fail++; $display("FAIL arst_post[%0d]: got r=%b v=%b want 0 0", k, read_a, valid_a); end
      tick();
    end
    en_a = 1'b1; #1;
    tick(); tick(); tick(); #1;
    n_checks++; if ({valid_a, data_a} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL arst_restart: got v=%b d=%0d want v=1 d=1", valid_a, data_a); end
  endtask

  // 65537 handshakes: word_count passes 16'hFFFF and wraps to 1.
  task automatic test_wrap();
    int hs = 0;
    int cycles = 0;
    int data_err = 0;
    bit seen_ffff = 1'b0;
    apply_reset();
    en_a = 1'b1; empty_a = 1'b0; ready_a = 1'b1;
    #1;
    while (hs < 65537 && cycles < 70000) begin
      if (valid_a) begin
        if (data_a !== 8'(hs + 1)) data_err++;
        hs++;
      end
      tick();
      cycles++;
      if (hs == 65535 && !seen_ffff) begin
        seen_ffff = 1'b1;
        n_checks++; if (wc_a !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %0h want ffff", wc_a); end
      end
    end
    ready_a = 1'b0; en_a = 1'b0;
    #1;
    n_checks++; if (hs != 65537) begin n_fail++; $display("FAIL wrap_budget: got %0d handshakes want 65537", hs); end
    n_checks++; if (wc_a !== 16'd1) begin n_fail++; $display("FAIL wrap_wc: got %0d want 1", wc_a); end
    n_checks++; if (data_err != 0) begin n_fail++; $display("FAIL wrap_data: got %0d bad words want 0", data_err); end
  endtask

  // RD_LAT=2 stream: the first read is in c1 and the first word appears in c4.
  task automatic test_stream_lat2();
    apply_reset();
    en_b = 1'b1; empty_b = 1'b0; ready_b = 1'b1;
    #1;
    tick(); #1;                                        // c1
    n_checks++; if (read_b !== 1'b1) begin n_fail++; $display("FAIL lat2_c1_read: got %b want 1", read_b); end
    tick(); #1;                                        // c2
    n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL lat2_c2_valid: got %b want 0", valid_b); end
    tick(); #1;                                        // c3
    n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL lat2_c3_valid: got %b want 0", valid_b); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      n_checks++; if ({valid_b, data_b, wc_b} !== {1'b1, 8'(k + 1), 16'(k)}) begin n_fail++; $display("FAIL lat2_word[%0d]: got v=%b d=%0d wc=%0d want v=1 d=%0d wc=%0d", k, valid_b, data_b, wc_b, k + 1, k); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_midburst();
    test_drain();
    test_async_reset();
    test_stream_lat2();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
- Reader-side companion to the team's circular-queue FIFO controller and dual-port RAM.
- Watches the FIFO's empty flag and issues single-cycle read pulses to it.
- Absorbs the RAM's fixed read latency and presents the words downstream on a valid/ready stream.
- Sits between the FIFO (controller plus RAM) and any consumer that can stall.

Parameters:
WIDTH, 8, data word width in bits
RD_LAT, 1, cycles from a read pulse to the cycle in which rd_data holds that word; legal values 1 or 2
BUF_DEPTH, 4, internal elastic buffer entries (localparam, fixed; must be >= RD_LAT+2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  enable draining of the FIFO
empty  in  1  FIFO empty flag from the FIFO controller; must be valid in the cycle it is sampled
rd_data  in  WIDTH  RAM read data; valid exactly RD_LAT cycles after the read pulse
read  out  1  read request pulse to the FIFO controller (one word per cycle high)
out_valid  out  1  out_data holds a word
out_data  out  WIDTH  head word of the elastic buffer
out_ready  in  1  downstream accepts the word this cycle
busy  out  1  block not IDLE
word_count  out  16  total downstream handshakes since reset

Behaviour:
- Reset is asynchronous, active-low, and applies immediately when reset=0.
  - State goes to IDLE; buffer pointers and occupancy go to 0; the in-flight pipe is cleared (in-flight words are discarded); word_count goes to 0.
  - read=0, out_valid=0, busy=0; out_data=0 (storage cleared).
- States:
  - IDLE: en=1 -> RUN; otherwise stay in IDLE.
  - RUN: en=0 -> DRAIN; otherwise stay in RUN.
  - DRAIN: go to IDLE once inflight==0 and occ==0. en is ignored in DRAIN.
- read is combinational: read = (state==RUN) && !empty && (occ + inflight < BUF_DEPTH).
  - Never asserted in IDLE or DRAIN, or while empty=1.
- In-flight tracking: an RD_LAT-stage shift register of valid bits, fed by read; inflight = number of set bits.
  - When the last stage is set, rd_data is written into the buffer at the tail at that clock edge.
- Elastic buffer: circular, BUF_DEPTH entries.
  - out_valid = (occ != 0); out_data = entry at the head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: occ unchanged, both pointers advance.
  - Pointers wrap modulo BUF_DEPTH.
  - The credit rule guarantees no overflow; a push when occ==BUF_DEPTH is a design error, flagged by an assertion.
- Latency: read high in cycle t -> rd_data captured at the end of cycle t+RD_LAT -> out_valid=1 in cycle t+RD_LAT+1.
- Throughput: with empty=0 and out_ready=1 held, read stays high every cycle and out_valid stays high every cycle after the pipe fills.
- Backpressure: out_ready=0 holds out_data/out_valid stable. read deasserts once occ+inflight reaches BUF_DEPTH and resumes the cycle after a pop.
- en dropping mid-stream: no new reads; in-flight words still land; the buffer is delivered normally; busy stays 1 until IDLE.
- empty rising mid-burst: read drops the same cycle; already-issued reads still complete.
- word_count increments on each handshake and wraps from 16'hFFFF to 0.
- busy = (state != IDLE).

Test Plan:
1. Reset, en=1, empty=0, out_ready=1, rd_data = 1,2,3,... (RD_LAT=1) -> read high from cycle 1; out_valid first high 2 cycles after the first read; data 1,2,3 in order, one per cycle; word_count counts up.
2. Streaming, then out_ready=0 for 6 cycles -> read drops after occ+inflight=4; out_data frozen; no word lost or duplicated; resume yields a consecutive sequence.
3. empty=1 after 3 reads -> exactly 3 words delivered; read stays 0; out_valid drops after the third handshake; state remains RUN.
4. en=0 with 2 in flight and 1 buffered (RD_LAT=2) -> no further reads; 3 words delivered; busy falls the cycle after the buffer empties; en pulse during DRAIN is ignored.
5. Reset asserted asynchronously mid-burst -> read, out_valid, busy and word_count go to 0 immediately without a clock edge; after release the in-flight word is never emitted.
6. 65537 handshakes -> word_count reads 1 (wraparound); RD_LAT=2 rerun of scenario 1 shows first out_valid 3 cycles after the first read.
